// File: rtl/vmem_phys_mem_port.sv
// Word-addressed physical RAM behind a 4-phase req/ack port with programmable latency,
// plus a back-door load port and read/write/range-error bookkeeping.
module vmem_phys_mem_port #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned LATENCY  = 3,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_ack,
    input  logic        i_ld_en,
    input  logic [31:0] i_ld_addr,
    input  logic [31:0] i_ld_data,
    output logic [31:0] o_rd_cnt,
    output logic [31:0] o_wr_cnt,
    output logic        o_range_err
);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    localparam logic [3:0] LatInit = 4'(LATENCY - 1);

    state_e            r_state;
    state_e            w_state_d;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic              r_oor;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_ack;
    logic [31:0]       r_rd_cnt;
    logic [31:0]       r_wr_cnt;
    logic              r_range_err;
    logic [31:0]       r_mem [2**ADDR_W];

    logic w_capture;
    logic w_access;
    logic w_ld_ok;
    logic w_unused;

    assign w_capture = (r_state == StIdle) && i_mem_req;
    assign w_access  = (r_state == StWait) && (r_cnt == 4'd0);
    assign w_ld_ok   = i_ld_en && (i_ld_addr[31:ADDR_W+2] == '0);
    // Byte-lane bits are ignored: the RAM is word access only.
    assign w_unused  = ^{i_mem_addr[1:0], i_ld_addr[1:0]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (i_mem_req) w_state_d = StWait;
            StWait:  if (r_cnt == 4'd0) w_state_d = StAck;
            StAck:   if (!i_mem_req) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= 4'd0;
            r_idx       <= '0;
            r_oor       <= 1'b0;
            r_we        <= 1'b0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_ack       <= 1'b0;
            r_rd_cnt    <= 32'd0;
            r_wr_cnt    <= 32'd0;
            r_range_err <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cnt   <= LatInit;
                r_idx   <= i_mem_addr[ADDR_W+1:2];
                r_oor   <= |i_mem_addr[31:ADDR_W+2];
                r_we    <= i_mem_we;
                r_wdata <= i_mem_wdata;
            end else if ((r_state == StWait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                r_ack <= 1'b1;
                if (r_oor) r_range_err <= 1'b1;
                if (r_we) begin
                    r_wr_cnt <= r_wr_cnt + 32'd1;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 32'd1;
                    r_rdata  <= r_oor ? ERR_DATA : r_mem[r_idx];
                end
            end else if ((r_state == StAck) && !i_mem_req) begin
                r_ack <= 1'b0;
            end
        end
    end

    // Handshake write is placed last so it wins a same-word collision with the back-door.
    always_ff @(posedge i_clk) begin
        if (w_ld_ok) r_mem[i_ld_addr[ADDR_W+1:2]] <= i_ld_data;
        if (w_access && r_we && !r_oor) r_mem[r_idx] <= r_wdata;
    end

    always_comb begin
        o_mem_ack   = r_ack;
        o_mem_rdata = r_rdata;
        o_rd_cnt    = r_rd_cnt;
        o_wr_cnt    = r_wr_cnt;
        o_range_err = r_range_err;
    end

endmodule

// File: tb/tb_vmem_phys_mem_port.sv
// Scoreboard bench for vmem_phys_mem_port: directed page-walk cases plus random traffic
// checked against an array model of the RAM.
module tb_vmem_phys_mem_port;

    localparam int unsigned AW    = 13;
    localparam int unsigned LAT   = 3;
    localparam int unsigned WORDS = 1 << AW;

    typedef struct {
        logic [31:0] rdata;
        int          edge_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, mem_we = 1'b0, ack, range_err;
    logic [31:0] addr = '0, wdata = '0, rdata, rd_cnt, wr_cnt;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0, ld_data = '0;

    logic        req1 = 1'b0, ack1, range_err1, ld_en1 = 1'b0;
    logic [31:0] addr1 = '0, rdata1, rd_cnt1, wr_cnt1, ld_addr1 = '0, ld_data1 = '0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] cur_rdata = '0;
    logic        ack_prev = 1'b0;

    logic [31:0] mem_m [WORDS];
    int          rd_exp = 0, wr_exp = 0;
    logic        err_exp = 1'b0;
    logic [31:0] model_rdata = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vmem_phys_mem_port #(.ADDR_W(AW), .LATENCY(LAT), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .i_clk(clk), .i_rst(rst), .i_mem_req(req), .i_mem_we(mem_we), .i_mem_addr(addr),
        .i_mem_wdata(wdata), .o_mem_rdata(rdata), .o_mem_ack(ack), .i_ld_en(ld_en),
        .i_ld_addr(ld_addr), .i_ld_data(ld_data), .o_rd_cnt(rd_cnt), .o_wr_cnt(wr_cnt),
        .o_range_err(range_err)
    );

    vmem_phys_mem_port #(.ADDR_W(AW), .LATENCY(1), .ERR_DATA(32'hDEAD_BEEF)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_mem_req(req1), .i_mem_we(1'b0), .i_mem_addr(addr1),
        .i_mem_wdata(32'd0), .o_mem_rdata(rdata1), .o_mem_ack(ack1), .i_ld_en(ld_en1),
        .i_ld_addr(ld_addr1), .i_ld_data(ld_data1), .o_rd_cnt(rd_cnt1), .o_wr_cnt(wr_cnt1),
        .o_range_err(range_err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_oor(input logic [31:0] a);
        return (a / (1 << (AW + 2))) != 0;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % WORDS);
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        if (!is_oor(a)) mem_m[widx(a)] = d;
    endtask

    task automatic chk_counters();
        chk("rd_cnt", rd_cnt, rd_exp);
        chk("wr_cnt", wr_cnt, wr_exp);
        chk("range_err", range_err, err_exp);
    endtask

    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                          input int hold, input bit early, input bit collide);
        exp_t e;
        int   n;
        bit   got;
        @(negedge clk);
        ld_en = 1'b0; req = 1'b1; mem_we = we; addr = a; wdata = d;
        n = cyc + 1;
        if (is_oor(a)) err_exp = 1'b1;
        if (we) begin
            wr_exp++;
            if (!is_oor(a)) mem_m[widx(a)] = d;
        end else begin
            rd_exp++;
            model_rdata = is_oor(a) ? 32'hDEAD_BEEF : mem_m[widx(a)];
        end
        e.rdata = model_rdata; e.edge_n = n;
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                mem_we = ~we; addr = $urandom; wdata = $urandom;
                if (early) req = 1'b0;
            end
            if (collide && cyc == n + LAT - 1) begin
                ld_en = 1'b1; ld_addr = a; ld_data = ~d;
            end else begin
                ld_en = 1'b0;
            end
            got = ack;
        end
        ld_en = 1'b0;
        chk("ack_rise", got, 1);
        if (!early) repeat (hold) @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("ack_fall", ack, 0);
        chk_counters();
    endtask

    // Monitor: pops an expectation on every ack rise and tracks the held read data.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            cur_rdata = '0;
            ack_prev  = 1'b0;
        end else begin
            if (ack && !ack_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    cur_rdata = mon_e.rdata;
                    chk("latency", cyc - mon_e.edge_n, LAT);
                end
            end
            chk("rdata", rdata, cur_rdata);
            ack_prev = ack;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run did not finish, %0d checks so far", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        bit          we;
        int          r;
        bit          got;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk_counters();
        rst = 1'b0;

        // LATENCY=1 instance: ack one edge after the capture edge
        @(negedge clk);
        ld_en1 = 1'b1; ld_addr1 = 32'h40; ld_data1 = 32'hA5A5_5A5A;
        @(negedge clk);
        ld_en1 = 1'b0; req1 = 1'b1; addr1 = 32'h40;
        @(posedge clk); #1;
        chk("lat1_capture_edge", ack1, 0);
        @(posedge clk); #1;
        chk("lat1_ack", ack1, 1);
        chk("lat1_rdata", rdata1, 32'hA5A5_5A5A);
        @(negedge clk);
        req1 = 1'b0;
        @(posedge clk); #1;
        chk("lat1_ack_fall", ack1, 0);
        chk("lat1_rd_cnt", rd_cnt1, 1);

        for (int i = 0; i < int'(WORDS); i++) load(i * 4, $urandom);

        load(32'h1000, 32'h0000_2000);
        access(1'b0, 32'h1000, 0, 0, 1'b0, 1'b0);
        load(32'h1004, 32'h0000_3000);
        load(32'h3008, 32'h0000_5000);
        access(1'b0, 32'h1004, 0, 1, 1'b0, 1'b0);
        access(1'b0, 32'h3008, 0, 0, 1'b0, 1'b0);
        access(1'b1, 32'h5010, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
        access(1'b0, 32'h5013, 0, 0, 1'b0, 1'b0);
        access(1'b0, 32'h8000_0000, 0, 0, 1'b0, 1'b0);
        access(1'b1, 32'h8000_0000, 32'h1234_5678, 0, 1'b0, 1'b0);
        access(1'b0, 32'h0000_0000, 0, 0, 1'b0, 1'b0);
        load(32'h8000_0010, 32'h7777_7777);
        access(1'b0, 32'h0000_0010, 0, 0, 1'b0, 1'b0);
        access(1'b0, 32'h1000, 0, 20, 1'b0, 1'b0);
        access(1'b0, 32'h3008, 0, 0, 1'b1, 1'b0);
        access(1'b1, 32'h0040, 32'h0BAD_F00D, 0, 1'b0, 1'b1);
        access(1'b0, 32'h0040, 0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 150; k++) begin
            we = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            if (r == 0) a = $urandom | (32'h1 << $urandom_range(31, AW + 2));
            else a = ($urandom_range(0, WORDS - 1) << 2) | $urandom_range(0, 3);
            access(we, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 9) == 0,
                   we && r != 0 && $urandom_range(0, 4) == 0);
        end

        // Reset while ack is high
        load(32'h2000, 32'h1111_2222);
        @(negedge clk);
        ld_en = 1'b0; req = 1'b1; mem_we = 1'b0; addr = 32'h2000;
        mon_e.rdata = mem_m[widx(32'h2000)]; mon_e.edge_n = cyc + 1;
        sb.push_back(mon_e);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = ack;
        end
        chk("rst_ack_rise", got, 1);
        rst = 1'b1;
        #1;
        chk("rst_in_ack_ack", ack, 0);
        chk("rst_in_ack_rdata", rdata, 0);
        rd_exp = 0; wr_exp = 0; err_exp = 1'b0; model_rdata = '0;
        chk_counters();
        @(negedge clk);
        req = 1'b0; rst = 1'b0;

        // Reset during the wait phase of a write: access abandoned
        @(negedge clk);
        req = 1'b1; mem_we = 1'b1; addr = 32'h2000; wdata = 32'h9999_0000;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_wait_ack", ack, 0);
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_abandon_ack", ack, 0);
        chk_counters();
        access(1'b0, 32'h2000, 0, 0, 1'b0, 1'b0);
        access(1'b0, 32'h1004, 0, 0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
